// File: rtl/crc_sequencer_pkg.sv
// Shared types for the CRC sequencer: FSM states, CRC_DR access sizes and
// the index of the final byte that the engine steps over for each size.
package crc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    // Size 2'b11 has no meaning on the bus, so it is stepped as a full word.
    function automatic logic [1:0] lastidx(input logic [1:0] size);
        case (size)
            BYTE:    lastidx = 2'd0;
            HALF:    lastidx = 2'd1;
            default: lastidx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/crc_sequencer_if.sv
// Signals between the AHB CRC host interface and the sequencer/datapath.
// The master modport is the host side; the slave modport is the sequencer.
interface crc_sequencer_if;
    logic [1:0] bus_size;
    logic       buffer_write_en;
    logic       reset_chain;
    logic       buffer_full;
    logic       read_wait;
    logic       reset_pending;
    logic       buffer_en;
    logic       load_data_en;
    logic [1:0] size_sel;
    logic [1:0] byte_sel;
    logic       calc_en;
    logic       crc_out_en;
    logic       crc_clear;

    modport master (
        output bus_size, buffer_write_en, reset_chain,
        input  buffer_full, read_wait, reset_pending, buffer_en, load_data_en,
        input  size_sel, byte_sel, calc_en, crc_out_en, crc_clear
    );

    modport slave (
        input  bus_size, buffer_write_en, reset_chain,
        output buffer_full, read_wait, reset_pending, buffer_en, load_data_en,
        output size_sel, byte_sel, calc_en, crc_out_en, crc_clear
    );
endinterface

// File: rtl/crc_sequencer.sv
// CRC_DR sequencer: one-entry staging buffer, byte-stepping FSM, deferred CR.RESET.
// Write at N -> load N+1, calc from N+2, crc_out_en one cycle after the last byte; stalls host via buffer_full.
module crc_sequencer
    import crc_seq_pkg::*;
(
    input  logic          HCLK,
    input  logic          HRESETn,
    crc_sequencer_if.slave bus
);

    state_e     state_q, state_d;
    logic       buff_valid_q, buff_valid_d;
    logic [1:0] buff_size_q, buff_size_d;
    logic [1:0] dat_size_q, dat_size_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic       crc_out_pend_q, crc_out_pend_d;
    logic       rst_req_q, rst_req_d;

    logic       last;
    logic       load_data_en;
    logic       buffer_full;
    logic       buffer_en;
    logic       calc_en;
    logic [1:0] byte_sel;
    logic       crc_clear;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= IDLE;
            buff_valid_q   <= 1'b0;
            buff_size_q    <= 2'b00;
            dat_size_q     <= 2'b00;
            byte_cnt_q     <= 2'b00;
            crc_out_pend_q <= 1'b0;
            rst_req_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            buff_valid_q   <= buff_valid_d;
            buff_size_q    <= buff_size_d;
            dat_size_q     <= dat_size_d;
            byte_cnt_q     <= byte_cnt_d;
            crc_out_pend_q <= crc_out_pend_d;
            rst_req_q      <= rst_req_d;
        end
    end

    always_comb begin
        last         = (byte_cnt_q == lastidx(dat_size_q));
        // A pending reset freezes the buffer so the clear lands between words.
        load_data_en = buff_valid_q && !rst_req_q &&
                       (state_q == IDLE || (state_q == CALC && last));
        // Flop-only stall term: no combinational path from buffer_write_en.
        buffer_full  = (buff_valid_q && !load_data_en) || rst_req_q;
        buffer_en    = bus.buffer_write_en && !buffer_full;

        state_d        = state_q;
        buff_valid_d   = buff_valid_q;
        buff_size_d    = buff_size_q;
        dat_size_d     = dat_size_q;
        byte_cnt_d     = byte_cnt_q;
        crc_out_pend_d = 1'b0;
        rst_req_d      = rst_req_q || bus.reset_chain;
        calc_en        = 1'b0;
        byte_sel       = 2'b00;
        crc_clear      = 1'b0;

        if (buffer_en) begin
            buff_valid_d = 1'b1;
            buff_size_d  = bus.bus_size;
        end else if (load_data_en) begin
            buff_valid_d = 1'b0;
        end

        if (load_data_en) begin
            dat_size_d = buff_size_q;
            byte_cnt_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (load_data_en) begin
                    state_d = CALC;
                end else if (rst_req_q && !crc_out_pend_q) begin
                    state_d = CLEAR;
                end
            end
            CALC: begin
                calc_en  = 1'b1;
                byte_sel = byte_cnt_q;
                if (!last) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end else begin
                    crc_out_pend_d = 1'b1;
                    state_d        = load_data_en ? CALC : IDLE;
                end
            end
            CLEAR: begin
                crc_clear = 1'b1;
                rst_req_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.buffer_full   = buffer_full;
    assign bus.buffer_en     = buffer_en;
    assign bus.load_data_en  = load_data_en;
    assign bus.read_wait     = buff_valid_q || (state_q != IDLE) || crc_out_pend_q || rst_req_q;
    assign bus.reset_pending = rst_req_q;
    assign bus.size_sel      = dat_size_q;
    assign bus.byte_sel      = byte_sel;
    assign bus.calc_en       = calc_en;
    assign bus.crc_out_en    = crc_out_pend_q;
    assign bus.crc_clear     = crc_clear;

endmodule

// File: tb/tb_crc_sequencer.sv
// Directed bench for crc_sequencer: per-cycle expected output vectors
// derived by hand from the sequencing rules, plus drain pulse counts.
module tb_crc_sequencer;

    logic HCLK;
    logic HRESETn;
    crc_sequencer_if bus ();

    crc_sequencer dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_err = 0;

    // {buffer_en, load_data_en, calc_en, byte_sel, crc_out_en, crc_clear,
    //  buffer_full, read_wait, reset_pending, size_sel}
    logic [11:0] obs;
    assign obs = {bus.buffer_en, bus.load_data_en, bus.calc_en, bus.byte_sel,
                  bus.crc_out_en, bus.crc_clear, bus.buffer_full, bus.read_wait,
                  bus.reset_pending, bus.size_sel};

    function automatic logic [11:0] V(input int be, input int ld, input int ce, input int bs,
                                      input int co, input int cc, input int bf, input int rw,
                                      input int rp, input int ss);
        V = {1'(be), 1'(ld), 1'(ce), 2'(bs), 1'(co), 1'(cc), 1'(bf), 1'(rw), 1'(rp), 2'(ss)};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int wr, input int sz, input int rc);
        bus.buffer_write_en = 1'(wr);
        bus.bus_size        = 2'(sz);
        bus.reset_chain     = 1'(rc);
    endtask

    // Check the current cycle mid-period, then move to just after the next edge.
    task automatic exp_cyc(input string tag, input logic [11:0] e);
        @(negedge HCLK);
        check(tag, {4'b0, obs}, {4'b0, e});
        @(posedge HCLK);
        #1;
    endtask

    task automatic drain(input string tag, input int exp_calc, input int exp_co);
        int  nc;
        int  no;
        int  ncl;
        bit  done;
        nc = 0; no = 0; ncl = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge HCLK);
            nc  += int'(bus.calc_en);
            no  += int'(bus.crc_out_en);
            ncl += int'(bus.crc_clear);
            if (!bus.read_wait) done = 1'b1;
            @(posedge HCLK);
            #1;
        end
        check({tag, "_done"}, {15'b0, done}, 16'd1);
        check({tag, "_calc"}, 16'(nc), 16'(exp_calc));
        check({tag, "_crcout"}, 16'(no), 16'(exp_co));
        check({tag, "_clear"}, 16'(ncl), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        drive(0, 0, 0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("reset_outs", {4'b0, obs}, 16'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        exp_cyc("rst_idle", V(0,0,0,0,0,0,0,0,0,0));

        // 1: single word write
        drive(1, 2, 0); exp_cyc("t1_wr",   V(1,0,0,0,0,0,0,0,0,0));
        drive(0, 2, 0); exp_cyc("t1_load", V(0,1,0,0,0,0,0,1,0,0));
        for (int b = 0; b < 4; b++) exp_cyc("t1_calc", V(0,0,1,b,0,0,0,1,0,2));
        exp_cyc("t1_crcout", V(0,0,0,0,1,0,0,1,0,2));
        exp_cyc("t1_idle",   V(0,0,0,0,0,0,0,0,0,2));

        // 2: back-to-back word writes, no bubble between words
        drive(1, 2, 0); exp_cyc("t2_wr0", V(1,0,0,0,0,0,0,0,0,2));
        drive(1, 2, 0); exp_cyc("t2_wr1", V(1,1,0,0,0,0,0,1,0,2));
        drive(0, 2, 0);
        for (int b = 0; b < 3; b++) exp_cyc("t2_calc_a", V(0,0,1,b,0,0,1,1,0,2));
        exp_cyc("t2_load2", V(0,1,1,3,0,0,0,1,0,2));
        exp_cyc("t2_calc_b0", V(0,0,1,0,1,0,0,1,0,2));
        for (int b = 1; b < 4; b++) exp_cyc("t2_calc_b", V(0,0,1,b,0,0,0,1,0,2));
        exp_cyc("t2_crcout2", V(0,0,0,0,1,0,0,1,0,2));
        exp_cyc("t2_idle",    V(0,0,0,0,0,0,0,0,0,2));

        // 3: third write stalls until the buffer drains
        drive(1, 2, 0); exp_cyc("t3_wr0", V(1,0,0,0,0,0,0,0,0,2));
        drive(1, 2, 0); exp_cyc("t3_wr1", V(1,1,0,0,0,0,0,1,0,2));
        for (int b = 0; b < 3; b++) exp_cyc("t3_full", V(0,0,1,b,0,0,1,1,0,2));
        exp_cyc("t3_accept", V(1,1,1,3,0,0,0,1,0,2));
        drive(0, 2, 0);
        drain("t3_drain", 8, 3);

        // 4: half write then byte write
        drive(1, 1, 0); exp_cyc("t4_wrh",  V(1,0,0,0,0,0,0,0,0,2));
        drive(1, 0, 0); exp_cyc("t4_wrb",  V(1,1,0,0,0,0,0,1,0,2));
        drive(0, 0, 0); exp_cyc("t4_h0",   V(0,0,1,0,0,0,1,1,0,1));
        exp_cyc("t4_h1",   V(0,1,1,1,0,0,0,1,0,1));
        exp_cyc("t4_b0",   V(0,0,1,0,1,0,0,1,0,0));
        exp_cyc("t4_out2", V(0,0,0,0,1,0,0,1,0,0));
        exp_cyc("t4_idle", V(0,0,0,0,0,0,0,0,0,0));

        // 5: reset_chain mid-word, stalled write accepted after CLEAR
        drive(1, 2, 0); exp_cyc("t5_wr",    V(1,0,0,0,0,0,0,0,0,0));
        drive(0, 2, 0); exp_cyc("t5_load",  V(0,1,0,0,0,0,0,1,0,0));
        exp_cyc("t5_c0",    V(0,0,1,0,0,0,0,1,0,2));
        drive(0, 2, 1); exp_cyc("t5_c1rst", V(0,0,1,1,0,0,0,1,0,2));
        drive(1, 2, 0); exp_cyc("t5_c2",    V(0,0,1,2,0,0,1,1,1,2));
        exp_cyc("t5_c3",    V(0,0,1,3,0,0,1,1,1,2));
        exp_cyc("t5_out",   V(0,0,0,0,1,0,1,1,1,2));
        exp_cyc("t5_wait",  V(0,0,0,0,0,0,1,1,1,2));
        exp_cyc("t5_clear", V(0,0,0,0,0,1,1,1,1,2));
        exp_cyc("t5_accept", V(1,0,0,0,0,0,0,0,0,2));
        drive(0, 2, 0); exp_cyc("t5_load2", V(0,1,0,0,0,0,0,1,0,2));
        drain("t5_drain", 4, 1);

        // 6: async reset during CALC with a word staged
        drive(1, 2, 0); exp_cyc("t6_wr0", V(1,0,0,0,0,0,0,0,0,2));
        drive(1, 2, 0); exp_cyc("t6_wr1", V(1,1,0,0,0,0,0,1,0,2));
        drive(0, 2, 0); exp_cyc("t6_c0",  V(0,0,1,0,0,0,1,1,0,2));
        #2;
        HRESETn = 1'b0;
        #1;
        check("t6_async", {4'b0, obs}, 16'd0);
        @(negedge HCLK);
        check("t6_held", {4'b0, obs}, 16'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 8; i++) exp_cyc("t6_quiet", V(0,0,0,0,0,0,0,0,0,0));
        drive(1, 0, 0); exp_cyc("t6_nwr",   V(1,0,0,0,0,0,0,0,0,0));
        drive(0, 0, 0); exp_cyc("t6_nload", V(0,1,0,0,0,0,0,1,0,0));
        exp_cyc("t6_ncalc", V(0,0,1,0,0,0,0,1,0,0));
        exp_cyc("t6_nout",  V(0,0,0,0,1,0,0,1,0,0));
        exp_cyc("t6_nidle", V(0,0,0,0,0,0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
